// File: rtl/qkv_line_scheduler_pkg.sv
// Shared definitions for the Q/K/V line scheduler: line width derivation,
// channel identifiers and FSM state encodings.
package qkv_line_scheduler_pkg;

    localparam int SYSTOLIC_UNIT_NUM = 8;
    localparam int TIME_STEPS        = 8;
    localparam int QKV_LINE_W        = 2 * SYSTOLIC_UNIT_NUM * TIME_STEPS;
    localparam int NUM_CH            = 3;

    typedef enum logic [1:0] {
        QKV_Q = 2'd0,
        QKV_K = 2'd1,
        QKV_V = 2'd2
    } qkv_ch_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Round-robin successor: Q -> K -> V -> Q
    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return (ch == 2'(QKV_V)) ? 2'(QKV_Q) : ch + 2'd1;
    endfunction

endpackage

// File: rtl/qkv_line_scheduler_if.sv
// Line-stream bundle between the QKV reshape stage, the scheduler and the
// attention-buffer write port.
interface qkv_line_scheduler_if #(
    parameter int LINE_W = 128,
    parameter int IDX_W  = 4
);
    logic [3*LINE_W-1:0] i_line_data;
    logic [2:0]          i_line_valid;
    logic [LINE_W-1:0]   o_line_data;
    logic [1:0]          o_line_sel;
    logic [IDX_W-1:0]    o_line_idx;
    logic                o_line_valid;
    logic                i_line_ready;

    modport master (
        output i_line_data, i_line_valid, i_line_ready,
        input  o_line_data, o_line_sel, o_line_idx, o_line_valid
    );

    modport slave (
        input  i_line_data, i_line_valid, i_line_ready,
        output o_line_data, o_line_sel, o_line_idx, o_line_valid
    );
endinterface

// File: rtl/qkv_line_fifo.sv
// Small synchronous FIFO with a registered occupancy count; the head word is
// visible on rdata whenever the FIFO is non-empty.
module qkv_line_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    // Head read is combinational so the scheduler can load it in the grant cycle
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/qkv_line_scheduler.sv
// Merges the Q/K/V line streams into one valid/ready port: per-channel FIFOs,
// round-robin grant into an output register, per-channel line counting and tile FSM.
module qkv_line_scheduler
    import qkv_line_scheduler_pkg::*;
#(
    parameter int LINE_W         = QKV_LINE_W,
    parameter int FIFO_DEPTH     = 4,
    parameter int LINES_PER_TILE = 16
) (
    input  logic                      s_clk,
    input  logic                      s_rst_n,
    input  logic                      i_start,
    input  logic                      i_clr_err,
    qkv_line_scheduler_if.slave       line_if,
    output logic                      o_busy,
    output logic                      o_tile_done,
    output logic [2:0]                o_ovf,
    output logic [2:0]                o_drop
);
    localparam int IDX_W = $clog2(LINES_PER_TILE);
    localparam int CNT_W = $clog2(LINES_PER_TILE + 1);
    localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] TILE_CNT = CNT_W'(LINES_PER_TILE);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  in_cnt_q [NUM_CH];
    logic [CNT_W-1:0]  in_cnt_d [NUM_CH];
    logic [CNT_W-1:0]  out_cnt_q [NUM_CH];
    logic [CNT_W-1:0]  out_cnt_d [NUM_CH];
    logic [1:0]        rr_q, rr_d;
    logic [LINE_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_sel_q, out_sel_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              out_valid_q, out_valid_d;
    logic [2:0]        ovf_q, ovf_d;
    logic [2:0]        drop_q, drop_d;

    logic [2:0]        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [LINE_W-1:0] fifo_rdata [NUM_CH];
    logic [FC_W-1:0]   fifo_cnt [NUM_CH];
    logic [2:0]        in_accept, ovf_set, drop_set;
    logic              load, grant_valid, tile_drained;
    logic [1:0]        grant, cand;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            qkv_line_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (LINE_W)
            ) u_fifo (
                .clk   (s_clk),
                .rst_n (s_rst_n),
                .push  (fifo_push[gi]),
                .pop   (fifo_pop[gi]),
                .wdata (line_if.i_line_data[gi*LINE_W +: LINE_W]),
                .rdata (fifo_rdata[gi]),
                .full  (fifo_full[gi]),
                .empty (fifo_empty[gi]),
                .count (fifo_cnt[gi])
            );
        end
    endgenerate

    always_comb begin
        // Round-robin search starting at the pointer
        load        = !out_valid_q || line_if.i_line_ready;
        grant_valid = 1'b0;
        grant       = rr_q;
        cand        = rr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant       = cand;
            end
            cand = next_ch(cand);
        end

        fifo_pop    = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_idx_d   = out_idx_q;
        out_cnt_d   = out_cnt_q;
        in_cnt_d    = in_cnt_q;
        rr_d        = rr_q;

        if (load) begin
            out_valid_d = grant_valid;
            if (grant_valid) begin
                fifo_pop[grant]  = 1'b1;
                out_data_d       = fifo_rdata[grant];
                out_sel_d        = grant;
                out_idx_d        = out_cnt_q[grant][IDX_W-1:0];
                out_cnt_d[grant] = out_cnt_q[grant] + CNT_W'(1);
                rr_d             = next_ch(grant);
            end
        end

        // Overflowed lines still count toward the tile, so a lossy tile never completes
        in_accept = '0;
        drop_set  = '0;
        ovf_set   = '0;
        fifo_push = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            in_accept[c] = line_if.i_line_valid[c] && (state_q == ST_RUN) &&
                           (in_cnt_q[c] != TILE_CNT);
            drop_set[c]  = line_if.i_line_valid[c] && !in_accept[c];
            ovf_set[c]   = in_accept[c] && fifo_full[c] && !fifo_pop[c];
            fifo_push[c] = in_accept[c] && !ovf_set[c];
            if (in_accept[c]) begin
                in_cnt_d[c] = in_cnt_q[c] + CNT_W'(1);
            end
        end

        ovf_d  = (i_clr_err ? 3'b000 : ovf_q)  | ovf_set;
        drop_d = (i_clr_err ? 3'b000 : drop_q) | drop_set;

        tile_drained = !out_valid_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (out_cnt_q[c] != TILE_CNT || fifo_cnt[c] != '0) begin
                tile_drained = 1'b0;
            end
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    rr_d    = 2'(QKV_Q);
                    for (int c = 0; c < NUM_CH; c++) begin
                        in_cnt_d[c]  = '0;
                        out_cnt_d[c] = '0;
                    end
                end
            end
            ST_RUN:  if (tile_drained) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q     <= ST_IDLE;
            rr_q        <= 2'(QKV_Q);
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= '0;
            drop_q      <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                in_cnt_q[c]  <= '0;
                out_cnt_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            for (int c = 0; c < NUM_CH; c++) begin
                in_cnt_q[c]  <= in_cnt_d[c];
                out_cnt_q[c] <= out_cnt_d[c];
            end
        end
    end

    assign line_if.o_line_data  = out_data_q;
    assign line_if.o_line_sel   = out_sel_q;
    assign line_if.o_line_idx   = out_idx_q;
    assign line_if.o_line_valid = out_valid_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_tile_done = (state_q == ST_DONE);
    assign o_ovf       = ovf_q;
    assign o_drop      = drop_q;

endmodule

// File: tb/tb_qkv_line_scheduler.sv
// Self-checking bench for qkv_line_scheduler: per-channel scoreboard queues,
// a table of control/error vectors and hand-written stall/reset sequences.
module tb_qkv_line_scheduler;
    import qkv_line_scheduler_pkg::*;

    localparam int LW    = 128;
    localparam int DEPTH = 4;
    localparam int LPT   = 16;
    localparam int IDX_W = 4;

    logic       s_clk     = 1'b0;
    logic       s_rst_n   = 1'b0;
    logic       i_start   = 1'b0;
    logic       i_clr_err = 1'b0;
    logic       o_busy, o_tile_done;
    logic [2:0] o_ovf, o_drop;

    qkv_line_scheduler_if #(.LINE_W(LW), .IDX_W(IDX_W)) lif ();

    qkv_line_scheduler #(
        .LINE_W         (LW),
        .FIFO_DEPTH     (DEPTH),
        .LINES_PER_TILE (LPT)
    ) dut (
        .s_clk       (s_clk),
        .s_rst_n     (s_rst_n),
        .i_start     (i_start),
        .i_clr_err   (i_clr_err),
        .line_if     (lif),
        .o_busy      (o_busy),
        .o_tile_done (o_tile_done),
        .o_ovf       (o_ovf),
        .o_drop      (o_drop)
    );

    always #5 s_clk = ~s_clk;

    typedef struct packed {
        logic [LW-1:0]    data;
        logic [IDX_W-1:0] idx;
    } exp_t;

    typedef struct {
        logic       start;
        logic       clr;
        logic [2:0] valid;
        logic       exp_busy;
        logic [2:0] exp_drop;
        logic       exp_valid;
    } vec_t;

    exp_t       eq_q[$], eq_k[$], eq_v[$];
    logic [1:0] sel_log[$];
    int         in_idx [3];
    int         checks   = 0;
    int         errors   = 0;
    int         done_cnt = 0;
    logic       rdy_rand = 1'b0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int c);
        case (c)
            0:       return eq_q.size();
            1:       return eq_k.size();
            2:       return eq_v.size();
            default: return 0;
        endcase
    endfunction

    function automatic exp_t pop_exp(input int c);
        case (c)
            0:       return eq_q.pop_front();
            1:       return eq_k.pop_front();
            default: return eq_v.pop_front();
        endcase
    endfunction

    function automatic void push_exp(input int c, input logic [LW-1:0] d);
        exp_t e;
        e.data = d;
        e.idx  = IDX_W'(in_idx[c]);
        in_idx[c]++;
        case (c)
            0:       eq_q.push_back(e);
            1:       eq_k.push_back(e);
            default: eq_v.push_back(e);
        endcase
    endfunction

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge s_clk);
        #1;
        if (rdy_rand) lif.i_line_ready = 1'($urandom_range(0, 1));
    endtask

    // Drive one cycle of lines; acc marks the ones expected to reach the output
    task automatic send(input logic [2:0] mask, input logic [2:0] acc);
        logic [LW-1:0] d;
        for (int c = 0; c < 3; c++) begin
            d = rnd_line();
            lif.i_line_data[c*LW +: LW] = d;
            if (acc[c]) push_exp(c, d);
        end
        lif.i_line_valid = mask;
        tick();
        lif.i_line_valid = 3'b000;
    endtask

    task automatic start_tile();
        for (int c = 0; c < 3; c++) in_idx[c] = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while ((qsize(0) + qsize(1) + qsize(2)) != 0 && n < 400) begin
            tick();
            n++;
        end
        chk(name, LW'(qsize(0) + qsize(1) + qsize(2)), '0);
    endtask

    task automatic wait_done(input string name, input int target);
        int n = 0;
        while (done_cnt < target && n < 600) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk(name, LW'(done_cnt), LW'(target));
        chk({name, "_idle"}, LW'(o_busy), '0);
    endtask

    task automatic monitor();
        exp_t             e;
        logic             stall_prev = 1'b0;
        logic [LW-1:0]    pd;
        logic [1:0]       ps;
        logic [IDX_W-1:0] pi;
        forever begin
            @(negedge s_clk);
            if (!s_rst_n) begin
                stall_prev = 1'b0;
                continue;
            end
            if (o_tile_done) done_cnt++;
            if (stall_prev) begin
                chk("hold_valid", LW'(lif.o_line_valid), LW'(1));
                chk("hold_data", lif.o_line_data, pd);
                chk("hold_sel", LW'(lif.o_line_sel), LW'(ps));
                chk("hold_idx", LW'(lif.o_line_idx), LW'(pi));
            end
            stall_prev = lif.o_line_valid && !lif.i_line_ready;
            pd = lif.o_line_data;
            ps = lif.o_line_sel;
            pi = lif.o_line_idx;
            if (lif.o_line_valid && lif.i_line_ready) begin
                sel_log.push_back(lif.o_line_sel);
                $display("OUT sel=%0d idx=%0d data=%h", lif.o_line_sel, lif.o_line_idx, lif.o_line_data);
                if (qsize(int'(lif.o_line_sel)) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_line: got sel %0d idx %0d, expected no line outstanding",
                             lif.o_line_sel, lif.o_line_idx);
                end else begin
                    e = pop_exp(int'(lif.o_line_sel));
                    chk("line_data", lif.o_line_data, e.data);
                    chk("line_idx", LW'(lif.o_line_idx), LW'(e.idx));
                end
            end
        end
    endtask

    initial begin
        vec_t tbl [7];
        int   saved_done;
        int   rem [3];
        int   n;
        logic [2:0] m;

        tbl[0] = '{start: 1'b0, clr: 1'b0, valid: 3'b111, exp_busy: 1'b0, exp_drop: 3'b111, exp_valid: 1'b0};
        tbl[1] = '{start: 1'b0, clr: 1'b1, valid: 3'b000, exp_busy: 1'b0, exp_drop: 3'b000, exp_valid: 1'b0};
        tbl[2] = '{start: 1'b0, clr: 1'b1, valid: 3'b010, exp_busy: 1'b0, exp_drop: 3'b010, exp_valid: 1'b0};
        tbl[3] = '{start: 1'b0, clr: 1'b0, valid: 3'b100, exp_busy: 1'b0, exp_drop: 3'b110, exp_valid: 1'b0};
        tbl[4] = '{start: 1'b0, clr: 1'b1, valid: 3'b000, exp_busy: 1'b0, exp_drop: 3'b000, exp_valid: 1'b0};
        tbl[5] = '{start: 1'b1, clr: 1'b0, valid: 3'b000, exp_busy: 1'b1, exp_drop: 3'b000, exp_valid: 1'b0};
        tbl[6] = '{start: 1'b1, clr: 1'b0, valid: 3'b000, exp_busy: 1'b1, exp_drop: 3'b000, exp_valid: 1'b0};

        lif.i_line_data  = '0;
        lif.i_line_valid = 3'b000;
        lif.i_line_ready = 1'b1;
        for (int c = 0; c < 3; c++) in_idx[c] = 0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge s_clk);
        #1;
        chk("rst_valid", LW'(lif.o_line_valid), '0);
        chk("rst_data", lif.o_line_data, '0);
        chk("rst_busy", LW'(o_busy), '0);
        chk("rst_done", LW'(o_tile_done), '0);
        chk("rst_ovf", LW'(o_ovf), '0);
        chk("rst_drop", LW'(o_drop), '0);
        s_rst_n = 1'b1;
        tick();

        // 1: one tile, lines on separate cycles
        start_tile();
        chk("t1_busy", LW'(o_busy), LW'(1));
        sel_log.delete();
        for (int i = 0; i < 3 * LPT; i++) send(3'(1 << (i % 3)), 3'(1 << (i % 3)));
        wait_empty("t1_empty");
        wait_done("t1_done", 1);
        chk("t1_count", LW'(sel_log.size()), LW'(3 * LPT));
        chk("t1_ovf", LW'(o_ovf), '0);
        chk("t1_drop", LW'(o_drop), '0);

        // 2: all three channels at once, round-robin order
        start_tile();
        sel_log.delete();
        for (int g = 0; g < 4; g++) begin
            repeat (4) send(3'b111, 3'b111);
            wait_empty("t2_empty");
        end
        wait_done("t2_done", 2);
        chk("t2_count", LW'(sel_log.size()), LW'(3 * LPT));
        if (sel_log.size() == 3 * LPT) begin
            for (int i = 0; i < 3 * LPT; i++) chk("t2_rr_order", LW'(sel_log[i]), LW'(i % 3));
        end
        chk("t2_ovf", LW'(o_ovf), '0);

        // 3: stall, fill FIFO plus output register, then overflow
        start_tile();
        lif.i_line_ready = 1'b0;
        repeat (5) send(3'b001, 3'b001);
        tick();
        tick();
        chk("t3_valid", LW'(lif.o_line_valid), LW'(1));
        chk("t3_head_data", lif.o_line_data, eq_q[0].data);
        chk("t3_head_idx", LW'(lif.o_line_idx), '0);
        chk("t3_no_ovf", LW'(o_ovf), '0);
        send(3'b001, 3'b000);
        chk("t3_ovf", LW'(o_ovf), LW'(3'b001));
        lif.i_line_ready = 1'b1;
        wait_empty("t3_empty");

        // 5: reset mid-tile with lines buffered and output held
        lif.i_line_ready = 1'b0;
        send(3'b111, 3'b111);
        send(3'b111, 3'b111);
        tick();
        saved_done = done_cnt;
        #2;
        s_rst_n = 1'b0;
        #1;
        chk("t5_valid", LW'(lif.o_line_valid), '0);
        chk("t5_data", lif.o_line_data, '0);
        chk("t5_busy", LW'(o_busy), '0);
        chk("t5_ovf", LW'(o_ovf), '0);
        eq_q.delete();
        eq_k.delete();
        eq_v.delete();
        lif.i_line_ready = 1'b1;
        tick();
        s_rst_n = 1'b1;
        tick();
        chk("t5_no_done", LW'(done_cnt), LW'(saved_done));
        start_tile();
        for (int i = 0; i < 3 * LPT; i++) send(3'(1 << (i % 3)), 3'(1 << (i % 3)));
        wait_empty("t5_empty");
        wait_done("t5_done", saved_done + 1);
        chk("t5_drop", LW'(o_drop), '0);

        // 4: drops outside RUN, sticky clear, set-wins, then a 17th line in RUN
        for (int i = 0; i < 7; i++) begin
            i_start          = tbl[i].start;
            i_clr_err        = tbl[i].clr;
            lif.i_line_valid = tbl[i].valid;
            tick();
            i_start          = 1'b0;
            i_clr_err        = 1'b0;
            lif.i_line_valid = 3'b000;
            chk("t4_busy", LW'(o_busy), LW'(tbl[i].exp_busy));
            chk("t4_drop", LW'(o_drop), LW'(tbl[i].exp_drop));
            chk("t4_valid", LW'(lif.o_line_valid), LW'(tbl[i].exp_valid));
            chk("t4_ovf", LW'(o_ovf), '0);
        end
        for (int c = 0; c < 3; c++) in_idx[c] = 0;
        repeat (LPT) send(3'b001, 3'b001);
        chk("t4_no_drop", LW'(o_drop), '0);
        send(3'b001, 3'b000);
        chk("t4_drop17", LW'(o_drop), LW'(3'b001));
        repeat (LPT) send(3'b010, 3'b010);
        repeat (LPT) send(3'b100, 3'b100);
        wait_empty("t4_empty");
        wait_done("t4_done", saved_done + 2);
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        chk("t4_clr", LW'(o_drop), '0);

        // 6: random ready over three tiles
        rdy_rand = 1'b1;
        for (int t = 0; t < 3; t++) begin
            start_tile();
            for (int c = 0; c < 3; c++) rem[c] = LPT;
            n = 0;
            while ((rem[0] + rem[1] + rem[2]) != 0 && n < 3000) begin
                m = 3'b000;
                for (int c = 0; c < 3; c++) begin
                    if (rem[c] > 0 && qsize(c) < DEPTH && $urandom_range(0, 1) == 1) begin
                        m[c] = 1'b1;
                        rem[c]--;
                    end
                end
                send(m, m);
                n++;
            end
            chk("t6_sent", LW'(rem[0] + rem[1] + rem[2]), '0);
            wait_empty("t6_empty");
            wait_done("t6_done", saved_done + 3 + t);
        end
        rdy_rand = 1'b0;
        lif.i_line_ready = 1'b1;
        chk("t6_ovf", LW'(o_ovf), '0);
        chk("t6_drop", LW'(o_drop), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
